// File: rtl/pc_gen_pkg.sv
// pc_gen shared types: widths, FSM states and fetch exception causes.
// Imported by the PC stage and its next-PC target unit.
package pc_gen_pkg;

  localparam int PC_WIDTH_DEF = 32;
  localparam int XLEN_DEF     = 32;

  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_TRAP = 2'd2,
    PCG_HALT = 2'd3
  } pcg_state_e;

  localparam logic [3:0] EXC_IADDR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_IACCESS_FAULT  = 4'd1;

endpackage

// File: rtl/pc_gen_target.sv
// Combinational next-PC selection for the non-exception, non-stall path:
// mret, jalr, jal/taken branch, sequential.
module pc_gen_target
  import pc_gen_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int XLEN     = XLEN_DEF
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                jal_i,
  input  logic                jalr_i,
  input  logic                branch_i,
  input  logic                br_taken_i,
  input  logic                mret_i,
  input  logic [XLEN-1:0]     imm_i,
  input  logic [XLEN-1:0]     jalr_rs1_i,
  input  logic [PC_WIDTH-1:0] mepc_i,
  output logic [PC_WIDTH-1:0] npc_o
);

  logic [XLEN-1:0]     jalr_sum;
  logic [PC_WIDTH-1:0] jalr_tgt;
  logic [PC_WIDTH-1:0] rel_tgt;
  logic [PC_WIDTH-1:0] seq_tgt;

  assign jalr_sum = jalr_rs1_i + imm_i;
  assign jalr_tgt = jalr_sum[PC_WIDTH-1:0] & ~PC_WIDTH'(1);
  assign rel_tgt  = pc_i + imm_i[PC_WIDTH-1:0];
  assign seq_tgt  = pc_i + PC_WIDTH'(4);

  // Several selects may be high together; earlier arms win.
  always_comb begin
    npc_o = seq_tgt;
    priority case (1'b1)
      mret_i:                          npc_o = mepc_i;
      jalr_i:                          npc_o = jalr_tgt;
      (jal_i | (branch_i & br_taken_i)): npc_o = rel_tgt;
      default:                         npc_o = seq_tgt;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter stage: boot bubble, redirects, fetch-exception trap
// entry, and halt on a fault at the trap vector itself.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                     PC_WIDTH = PC_WIDTH_DEF,
  parameter int                     XLEN     = XLEN_DEF,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                stall_i,
  input  logic                jal_i,
  input  logic                jalr_i,
  input  logic                branch_i,
  input  logic                br_taken_i,
  input  logic [XLEN-1:0]     imm_i,
  input  logic [XLEN-1:0]     jalr_rs1_i,
  input  logic                if_pc_misalign_i,
  input  logic                if_bus_err_i,
  input  logic                mret_i,
  input  logic [PC_WIDTH-1:0] mepc_i,
  input  logic [PC_WIDTH-1:0] trap_vec_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                pc_valid_o,
  output logic                exc_valid_o,
  output logic [3:0]          exc_cause_o,
  output logic [PC_WIDTH-1:0] exc_pc_o,
  output logic                halted_o
);

  pcg_state_e          state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                valid_q;
  logic                exc_valid_q;
  logic [3:0]          exc_cause_q;
  logic [PC_WIDTH-1:0] exc_pc_q;
  logic                halted_q;
  logic                first_q;

  logic [PC_WIDTH-1:0] npc_d;
  logic [PC_WIDTH-1:0] vec_d;
  logic                exc_d;

  assign vec_d = trap_vec_i & ~PC_WIDTH'(3);
  assign exc_d = if_pc_misalign_i | if_bus_err_i;

  pc_gen_target #(
    .PC_WIDTH (PC_WIDTH),
    .XLEN     (XLEN)
  ) u_target (
    .pc_i       (pc_q),
    .jal_i      (jal_i),
    .jalr_i     (jalr_i),
    .branch_i   (branch_i),
    .br_taken_i (br_taken_i),
    .mret_i     (mret_i),
    .imm_i      (imm_i),
    .jalr_rs1_i (jalr_rs1_i),
    .mepc_i     (mepc_i),
    .npc_o      (npc_d)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= PCG_BOOT;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= 4'd0;
      exc_pc_q    <= '0;
      halted_q    <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      exc_valid_q <= 1'b0;
      unique case (state_q)
        PCG_BOOT: begin
          state_q <= PCG_RUN;
          valid_q <= 1'b1;
        end
        PCG_RUN: begin
          if (exc_d) begin
            valid_q <= 1'b0;
            if (first_q) begin
              state_q  <= PCG_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q     <= PCG_TRAP;
              pc_q        <= vec_d;
              exc_valid_q <= 1'b1;
              exc_pc_q    <= pc_q;
              exc_cause_q <= if_pc_misalign_i ? EXC_IADDR_MISALIGN
                                              : EXC_IACCESS_FAULT;
            end
          end else if (!stall_i) begin
            pc_q    <= npc_d;
            first_q <= 1'b0;
          end
        end
        PCG_TRAP: begin
          state_q <= PCG_RUN;
          pc_q    <= vec_d;
          valid_q <= 1'b1;
          first_q <= 1'b1;
        end
        PCG_HALT: begin
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid_q;
  assign exc_valid_o = exc_valid_q;
  assign exc_cause_o = exc_cause_q;
  assign exc_pc_o    = exc_pc_q;
  assign halted_o    = halted_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter stage directly upstream of instruction fetch.
- Holds the architectural PC and drives it onto the fetch `pc_i`.
- Each cycle it consumes fetch's mini-decode results (jal/jalr/branch, immediate, jalr rs1 data) and fetch exception flags, then registers the next PC.
- Sequences the reset-boot bubble, trap-vector redirect, mret return and the double-fault halt.

Parameters:
- PC_WIDTH, 32, PC/address width (equals `PC_WIDTH in defines.v).
- XLEN, 32, data width (equals `XLEN).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  synchronous active-low reset
- stall_i  in  1  hold PC this cycle (downstream not ready)
- jal_i  in  1  mini-decode: current instr is jal
- jalr_i  in  1  mini-decode: current instr is jalr
- branch_i  in  1  mini-decode: current instr is conditional branch
- br_taken_i  in  1  branch condition result for current instr
- imm_i  in  XLEN  mini-decode immediate, sign-extended
- jalr_rs1_i  in  XLEN  rs1 read data for jalr
- if_pc_misalign_i  in  1  fetch: pc_o misaligned
- if_bus_err_i  in  1  fetch: bus error on pc_o
- mret_i  in  1  current instr is mret
- mepc_i  in  PC_WIDTH  CSR mepc (mret target)
- trap_vec_i  in  PC_WIDTH  CSR mtvec base (trap target)
- pc_o  out  PC_WIDTH  current fetch address
- pc_valid_o  out  1  pc_o is a live fetch this cycle
- exc_valid_o  out  1  one-cycle pulse, fetch exception taken
- exc_cause_o  out  4  mcause code of taken exception
- exc_pc_o  out  PC_WIDTH  faulting PC (for mepc write)
- halted_o  out  1  core halted by double fault

Behaviour:
- Reset:
  - Synchronous, active-low, only on clk_i edge with rst_n_i=0.
  - Reset values: pc_o=RESET_PC, pc_valid_o=0, exc_valid_o=0, exc_cause_o=0, exc_pc_o=0, halted_o=0.
  - State goes to BOOT.
  - Reset overrides every other input and state, including a reset mid-trap or in HALT.
- States:
  - BOOT: one bubble cycle with pc_valid_o=0 and pc_o held. Next state RUN with pc_valid_o=1.
  - RUN:
    - pc_valid_o=1.
    - Next PC is selected by the priority list below; the selected value is registered into pc_o at the clock edge.
  - TRAP:
    - Entered the cycle after a fetch exception is taken.
    - pc_valid_o=0; pc_o <= {trap_vec_i[PC_WIDTH-1:2],2'b00}.
    - Next state RUN, with a first-fetch flag set.
  - HALT:
    - pc_valid_o=0, halted_o=1, pc_o frozen.
    - Exit only via reset.
- Next-PC priority in RUN, highest first:
  1. Fetch exception.
     - Condition: if_pc_misalign_i | if_bus_err_i.
     - If the first-fetch flag is set (fault at the trap vector itself): go to HALT.
     - Otherwise go to TRAP. In the same edge: exc_valid_o<=1, exc_pc_o<=pc_o, exc_cause_o<=0 if misaligned else 1. Misalign wins over bus error.
     - Exceptions are honoured even when stall_i=1.
  2. stall_i=1: pc_o held.
  3. mret_i: pc_o <= mepc_i.
  4. jalr_i: pc_o <= (jalr_rs1_i + imm_i) & ~1.
  5. jal_i, or branch_i & br_taken_i: pc_o <= pc_o + imm_i.
  6. Otherwise: pc_o <= pc_o + 4.
- The first-fetch flag clears after any non-stalled RUN cycle that takes no exception.
- Arithmetic:
  - All adds are modulo 2^PC_WIDTH; wrap-around is silent.
  - The adder result is truncated to PC_WIDTH.
- Misaligned targets:
  - A misaligned target is not checked here. It is loaded into pc_o and detected by fetch on the next cycle through if_pc_misalign_i.
- exc_valid_o is high exactly one cycle; exc_cause_o and exc_pc_o hold their values until the next exception.
- Inputs are ignored when pc_valid_o=0.
- Single-cycle core: zero-latency redirect; the target is fetched on the cycle after the jump instruction.

Decomposition:
- Shared package / defines.v:
  - PC_WIDTH, XLEN.
  - State encodings PCG_BOOT/RUN/TRAP/HALT.
  - Cause constants EXC_IADDR_MISALIGN=0, EXC_IACCESS_FAULT=1.
- One natural sub-module: pc_gen_target, the combinational next-PC mux/adder (priorities 3–6).
- The FSM and registers stay in pc_gen.

Test Plan:
- Reset with RESET_PC=0x100, release -> cycle 1 pc_valid_o=0, pc_o=0x100; then 0x100, 0x104, 0x108 on successive cycles.
- pc=0x200, jal_i=1, imm=0xFFFFFFF0 -> next pc=0x1F0. Repeat with branch_i=1, br_taken_i=0 -> next pc=0x204.
- jalr_i=1, rs1=0x1003, imm=0x4 -> pc=0x1006. Then if_pc_misalign_i=1 -> exc_valid_o pulse, cause=0, exc_pc=0x1006. Next cycle pc=trap_vec 0x80 with pc_valid_o=0, then RUN at 0x80.
- At the first fetch of trap vector 0x80, if_bus_err_i=1 -> halted_o=1, pc frozen at 0x80. Assert rst_n_i=0 -> full reset values restored.
- stall_i=1 for 3 cycles at pc=0x300 with jal_i=1 -> pc held at 0x300. Stall with simultaneous if_bus_err_i=1 -> exception taken, cause=1.
- pc=0xFFFFFFFC, no jump -> next pc=0x00000000 (wrap). mret_i with mepc=0x444 while jalr_i=1 -> pc=0x444.
